// File: rtl/csr_access_unit.sv
// CSR access unit: initiator side of the core's CSR register-file port.
// It takes one decoded SYSTEM-class instruction at a time from decode.
// CSR instructions run read -> modify -> write on the CSR file.
// ecall pulses trap entry, and mret redirects the PC to mepc.
// Each request produces exactly one rd-writeback and/or redirect response.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  // request from decode
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        sys_op_i,
  input  logic [2:0]        funct3_i,
  input  logic [CSR_AW-1:0] csr_index_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [4:0]        rd_i,
  input  logic [XLEN-1:0]   pc_i,
  // CSR file port
  output logic [CSR_AW-1:0] csr_index_o,
  output logic              csr_wen_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              is_ecall_o,
  output logic [XLEN-1:0]   pc_o,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  // response to writeback / fetch
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              rd_wen_o,
  output logic [4:0]        rd_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              illegal_o
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_TRAP, S_RESP} state_t;

  state_t            r_state;
  // latched request fields
  logic [2:0]        r_funct3;
  logic [4:0]        r_rs1_idx;
  logic [XLEN-1:0]   r_rs1_data;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_old;
  // registered outputs
  logic [CSR_AW-1:0] r_csr_index;
  logic              r_csr_wen;
  logic [XLEN-1:0]   r_csr_wdata;
  logic              r_is_ecall;
  logic [XLEN-1:0]   r_pc;
  logic              r_out_valid;
  logic              r_rd_wen;
  logic [4:0]        r_rd_o;
  logic [XLEN-1:0]   r_rd_data;
  logic              r_redirect;
  logic [XLEN-1:0]   r_redirect_pc;
  logic              r_illegal;

  logic [XLEN-1:0]   w_src;
  logic [XLEN-1:0]   w_new;
  logic              w_do_write;

  // Ready only in IDLE, and held low while reset is asserted so every output reads 0.
  assign in_ready_o = (r_state == S_IDLE) && !rst;

  // Modify step: the source operand is rs1 data or zimm, combined with the CSR value read this cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    w_src      = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_data;
    w_new      = w_src;
    w_do_write = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
    case (r_funct3[1:0])
      2'b10:   w_new = csr_rdata_i | w_src;
      2'b11:   w_new = csr_rdata_i & ~w_src;
      default: w_new = w_src;
    endcase
  end

  // Sequencer FSM. All outputs are registered and set on entry to the state that drives them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state       <= S_IDLE;
      r_funct3      <= '0;
      r_rs1_idx     <= '0;
      r_rs1_data    <= '0;
      r_rd          <= '0;
      r_old         <= '0;
      r_csr_index   <= '0;
      r_csr_wen     <= 1'b0;
      r_csr_wdata   <= '0;
      r_is_ecall    <= 1'b0;
      r_pc          <= '0;
      r_out_valid   <= 1'b0;
      r_rd_wen      <= 1'b0;
      r_rd_o        <= '0;
      r_rd_data     <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_illegal     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            r_funct3   <= funct3_i;
            r_rs1_idx  <= rs1_idx_i;
            r_rs1_data <= rs1_data_i;
            r_rd       <= rd_i;
            case (sys_op_i)
              2'b00: begin
                if (funct3_i[1:0] != 2'b00) begin
                  r_csr_index <= csr_index_i;
                  r_state     <= S_READ;
                end else begin
                  // funct3 000/100 is not a CSR op: report it without touching the CSR file
                  r_illegal   <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_RESP;
                end
              end
              2'b01: begin
                r_is_ecall <= 1'b1;
                r_pc       <= pc_i;
                r_state    <= S_TRAP;
              end
              2'b10: begin
                r_redirect    <= 1'b1;
                r_redirect_pc <= mepc_i;
                r_out_valid   <= 1'b1;
                r_state       <= S_RESP;
              end
              default: begin
                r_illegal   <= 1'b1;
                r_out_valid <= 1'b1;
                r_state     <= S_RESP;
              end
            endcase
          end
        end
        S_READ: begin
          r_old       <= csr_rdata_i;
          r_csr_wdata <= w_new;
          r_csr_wen   <= w_do_write;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          // the write lands at this edge, before the response, so a following access sees it
          r_csr_index <= '0;
          r_csr_wen   <= 1'b0;
          r_csr_wdata <= '0;
          r_out_valid <= 1'b1;
          r_rd_wen    <= (r_rd != 5'd0);
          r_rd_o      <= r_rd;
          r_rd_data   <= r_old;
          r_state     <= S_RESP;
        end
        S_TRAP: begin
          // the CSR file captures mepc/mcause at this same edge
          r_is_ecall    <= 1'b0;
          r_pc          <= '0;
          r_redirect    <= 1'b1;
          r_redirect_pc <= mtvec_i;
          r_out_valid   <= 1'b1;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (out_ready_i) begin
            r_out_valid   <= 1'b0;
            r_rd_wen      <= 1'b0;
            r_rd_o        <= '0;
            r_rd_data     <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_illegal     <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign csr_index_o   = r_csr_index;
  assign csr_wen_o     = r_csr_wen;
  assign csr_wdata_o   = r_csr_wdata;
  assign is_ecall_o    = r_is_ecall;
  assign pc_o          = r_pc;
  assign out_valid_o   = r_out_valid;
  assign rd_wen_o      = r_rd_wen;
  assign rd_o          = r_rd_o;
  assign rd_data_o     = r_rd_data;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign illegal_o     = r_illegal;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed testbench for csr_access_unit with a small behavioural CSR file as responder.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  sys_op_i;
  logic [2:0]  funct3_i;
  logic [11:0] csr_index_i;
  logic [4:0]  rs1_idx_i;
  logic [31:0] rs1_data_i;
  logic [4:0]  rd_i;
  logic [31:0] pc_i;
  logic [11:0] csr_index_o;
  logic        csr_wen_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;
  logic        is_ecall_o;
  logic [31:0] pc_o;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        rd_wen_o;
  logic [4:0]  rd_o;
  logic [31:0] rd_data_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        illegal_o;

  int n_checks = 0;
  int n_pass   = 0;

  // CSR file model
  bit [31:0]   mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_idx = '0;
  logic [31:0] pre_data = '0;
  int          n_wen = 0;
  int          n_ecall = 0;
  int          n_overlap = 0;

  always #5 clk = ~clk;

  csr_access_unit #(.XLEN(32), .CSR_AW(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .sys_op_i(sys_op_i), .funct3_i(funct3_i), .csr_index_i(csr_index_i),
    .rs1_idx_i(rs1_idx_i), .rs1_data_i(rs1_data_i), .rd_i(rd_i), .pc_i(pc_i),
    .csr_index_o(csr_index_o), .csr_wen_o(csr_wen_o), .csr_wdata_o(csr_wdata_o),
    .csr_rdata_i(csr_rdata_i), .is_ecall_o(is_ecall_o), .pc_o(pc_o),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rd_wen_o(rd_wen_o), .rd_o(rd_o), .rd_data_o(rd_data_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .illegal_o(illegal_o)
  );

  assign csr_rdata_i = mem[csr_index_o];
  assign mtvec_i     = mem[12'h305];
  assign mepc_i      = mem[12'h341];

  wire [150:0] all_out = {csr_index_o, csr_wen_o, csr_wdata_o, is_ecall_o, pc_o,
                          out_valid_o, rd_wen_o, rd_o, rd_data_o, redirect_o,
                          redirect_pc_o, illegal_o};

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    if (csr_wen_o) begin
      mem[csr_index_o] <= csr_wdata_o;
      n_wen <= n_wen + 1;
    end
    if (is_ecall_o) begin
      mem[12'h341] <= pc_o;
      mem[12'h342] <= 32'd11;
      n_ecall <= n_ecall + 1;
    end
    if (csr_wen_o && is_ecall_o) n_overlap <= n_overlap + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] d);
    pre_en = 1'b1; pre_idx = idx; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  // Present one request for one cycle; returns 1ns after the accept edge.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [11:0] idx,
                      input logic [4:0] r1i, input logic [31:0] r1d, input logic [4:0] rd,
                      input logic [31:0] pc);
    sys_op_i = op; funct3_i = f3; csr_index_i = idx;
    rs1_idx_i = r1i; rs1_data_i = r1d; rd_i = rd; pc_i = pc;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic xfer();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if (all_out !== '0) $display("FAIL reset_outputs: got %h expected 0", all_out); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", in_ready_o); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready_o); else n_pass++;
  endtask

  task automatic test_csrrw();
    send(2'b00, 3'b001, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 32'h0);
    n_checks++; if ({csr_index_o, csr_wen_o, out_valid_o} !== {12'h305, 1'b0, 1'b0})
      $display("FAIL rw_read_state: got %h/%b/%b expected 305/0/0", csr_index_o, csr_wen_o, out_valid_o); else n_pass++;
    tick();
    n_checks++; if ({csr_index_o, csr_wen_o, csr_wdata_o} !== {12'h305, 1'b1, 32'h8000_0100})
      $display("FAIL rw_write_state: got %h/%b/%h expected 305/1/80000100", csr_index_o, csr_wen_o, csr_wdata_o); else n_pass++;
    tick();
    n_checks++; if ({out_valid_o, rd_wen_o, rd_o, rd_data_o, redirect_o, csr_index_o} !== {1'b1, 1'b1, 5'd5, 32'h0, 1'b0, 12'h0})
      $display("FAIL rw_resp: got v=%b w=%b rd=%0d data=%h redir=%b idx=%h expected 1 1 5 0 0 0",
               out_valid_o, rd_wen_o, rd_o, rd_data_o, redirect_o, csr_index_o); else n_pass++;
    n_checks++; if (mtvec_i !== 32'h8000_0100) $display("FAIL rw_mtvec_updated: got %h expected 80000100", mtvec_i); else n_pass++;
    xfer();
    n_checks++; if ({out_valid_o, in_ready_o} !== 2'b01) $display("FAIL rw_after_xfer: got %b expected 01", {out_valid_o, in_ready_o}); else n_pass++;
  endtask

  task automatic test_set_clear();
    int wen_before;
    preload(12'h300, 32'h0000_1800);
    wen_before = n_wen;
    send(2'b00, 3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd7, 32'h0);
    tick();
    n_checks++; if (csr_wen_o !== 1'b0) $display("FAIL rs_x0_no_wen: got %b expected 0", csr_wen_o); else n_pass++;
    tick();
    n_checks++; if ({out_valid_o, rd_wen_o, rd_data_o} !== {1'b1, 1'b1, 32'h1800})
      $display("FAIL rs_x0_resp: got %b/%b/%h expected 1/1/1800", out_valid_o, rd_wen_o, rd_data_o); else n_pass++;
    n_checks++; if (n_wen !== wen_before || mem[12'h300] !== 32'h1800)
      $display("FAIL rs_x0_no_write: got wen_count=%0d mstatus=%h expected %0d 1800", n_wen, mem[12'h300], wen_before); else n_pass++;
    xfer();
    preload(12'h300, 32'h0000_1808);
    send(2'b00, 3'b111, 12'h300, 5'd8, 32'hFFFF_FFFF, 5'd0, 32'h0);
    tick();
    n_checks++; if ({csr_wen_o, csr_wdata_o} !== {1'b1, 32'h1800})
      $display("FAIL rci_write: got %b/%h expected 1/1800", csr_wen_o, csr_wdata_o); else n_pass++;
    tick();
    n_checks++; if ({out_valid_o, rd_wen_o, rd_data_o} !== {1'b1, 1'b0, 32'h1808})
      $display("FAIL rci_resp: got %b/%b/%h expected 1/0/1808", out_valid_o, rd_wen_o, rd_data_o); else n_pass++;
    n_checks++; if (mem[12'h300] !== 32'h1800) $display("FAIL rci_mstatus: got %h expected 1800", mem[12'h300]); else n_pass++;
    xfer();
  endtask

  task automatic test_back_to_back();
    preload(12'h340, 32'h0000_0F0F);
    send(2'b00, 3'b010, 12'h340, 5'd3, 32'h00FF_0000, 5'd1, 32'h0);
    tick();
    n_checks++; if ({csr_wen_o, csr_wdata_o} !== {1'b1, 32'h00FF_0F0F})
      $display("FAIL rs_write: got %b/%h expected 1/00ff0f0f", csr_wen_o, csr_wdata_o); else n_pass++;
    tick();
    n_checks++; if (rd_data_o !== 32'h0F0F) $display("FAIL rs_old: got %h expected 00000f0f", rd_data_o); else n_pass++;
    xfer();
    send(2'b00, 3'b011, 12'h340, 5'd4, 32'h0000_000F, 5'd2, 32'h0);
    tick();
    n_checks++; if ({csr_wen_o, csr_wdata_o} !== {1'b1, 32'h00FF_0F00})
      $display("FAIL b2b_rc_write: got %b/%h expected 1/00ff0f00", csr_wen_o, csr_wdata_o); else n_pass++;
    tick();
    n_checks++; if ({rd_o, rd_data_o} !== {5'd2, 32'h00FF_0F0F})
      $display("FAIL b2b_rc_old: got %0d/%h expected 2/00ff0f0f", rd_o, rd_data_o); else n_pass++;
    xfer();
    send(2'b00, 3'b101, 12'h340, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0);
    tick();
    n_checks++; if ({csr_wen_o, csr_wdata_o} !== {1'b1, 32'h0})
      $display("FAIL rwi_zero_write: got %b/%h expected 1/0", csr_wen_o, csr_wdata_o); else n_pass++;
    tick();
    n_checks++; if (rd_data_o !== 32'h00FF_0F00) $display("FAIL rwi_old: got %h expected 00ff0f00", rd_data_o); else n_pass++;
    xfer();
    n_checks++; if (mem[12'h340] !== 32'h0) $display("FAIL rwi_mscratch: got %h expected 0", mem[12'h340]); else n_pass++;
  endtask

  task automatic test_ecall();
    int ecall_before;
    ecall_before = n_ecall;
    send(2'b01, 3'b000, 12'h0, 5'd0, 32'h0, 5'd0, 32'h8000_0040);
    n_checks++; if ({is_ecall_o, pc_o, csr_wen_o, out_valid_o} !== {1'b1, 32'h8000_0040, 1'b0, 1'b0})
      $display("FAIL ecall_trap: got %b/%h/%b/%b expected 1/80000040/0/0", is_ecall_o, pc_o, csr_wen_o, out_valid_o); else n_pass++;
    tick();
    n_checks++; if ({out_valid_o, redirect_o, redirect_pc_o, rd_wen_o, is_ecall_o, pc_o} !== {1'b1, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'h0})
      $display("FAIL ecall_resp: got v=%b r=%b pc=%h w=%b e=%b pco=%h expected 1 1 80000100 0 0 0",
               out_valid_o, redirect_o, redirect_pc_o, rd_wen_o, is_ecall_o, pc_o); else n_pass++;
    n_checks++; if ({mem[12'h341], mem[12'h342]} !== {32'h8000_0040, 32'd11})
      $display("FAIL ecall_mepc_mcause: got %h/%0d expected 80000040/11", mem[12'h341], mem[12'h342]); else n_pass++;
    n_checks++; if (n_ecall !== ecall_before + 1) $display("FAIL ecall_one_pulse: got %0d expected %0d", n_ecall, ecall_before + 1); else n_pass++;
    xfer();
  endtask

  task automatic test_mret();
    int wen_before, ecall_before;
    preload(12'h341, 32'h8000_0044);
    wen_before = n_wen;
    ecall_before = n_ecall;
    send(2'b10, 3'b000, 12'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    n_checks++; if ({out_valid_o, redirect_o, redirect_pc_o, illegal_o, rd_wen_o} !== {1'b1, 1'b1, 32'h8000_0044, 1'b0, 1'b0})
      $display("FAIL mret_resp: got v=%b r=%b pc=%h ill=%b w=%b expected 1 1 80000044 0 0",
               out_valid_o, redirect_o, redirect_pc_o, illegal_o, rd_wen_o); else n_pass++;
    xfer();
    n_checks++; if (n_wen !== wen_before || n_ecall !== ecall_before)
      $display("FAIL mret_no_strobes: got wen=%0d ecall=%0d expected %0d %0d", n_wen, n_ecall, wen_before, ecall_before); else n_pass++;
  endtask

  task automatic test_stall();
    send(2'b00, 3'b010, 12'h300, 5'd0, 32'h0, 5'd3, 32'h0);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if ({out_valid_o, in_ready_o, rd_wen_o, rd_o, rd_data_o} !== {1'b1, 1'b0, 1'b1, 5'd3, 32'h1800})
        $display("FAIL stall_hold_%0d: got v=%b rdy=%b w=%b rd=%0d data=%h expected 1 0 1 3 1800",
                 i, out_valid_o, in_ready_o, rd_wen_o, rd_o, rd_data_o); else n_pass++;
    end
    xfer();
    n_checks++; if ({out_valid_o, in_ready_o} !== 2'b01) $display("FAIL stall_release: got %b expected 01", {out_valid_o, in_ready_o}); else n_pass++;
  endtask

  task automatic test_illegal();
    int wen_before, ecall_before;
    wen_before = n_wen;
    ecall_before = n_ecall;
    send(2'b00, 3'b100, 12'h300, 5'd5, 32'h1234, 5'd9, 32'h100);
    n_checks++; if ({out_valid_o, illegal_o, rd_wen_o, redirect_o, csr_wen_o, is_ecall_o, csr_index_o} !== {6'b110000, 12'h0})
      $display("FAIL illegal_f3_100: got %b idx=%h expected 110000 idx=0",
               {out_valid_o, illegal_o, rd_wen_o, redirect_o, csr_wen_o, is_ecall_o}, csr_index_o); else n_pass++;
    xfer();
    send(2'b11, 3'b001, 12'h300, 5'd5, 32'h1234, 5'd9, 32'h100);
    n_checks++; if ({out_valid_o, illegal_o, rd_wen_o, redirect_o} !== 4'b1100)
      $display("FAIL illegal_op11: got %b expected 1100", {out_valid_o, illegal_o, rd_wen_o, redirect_o}); else n_pass++;
    xfer();
    n_checks++; if (n_wen !== wen_before || n_ecall !== ecall_before || mem[12'h300] !== 32'h1800)
      $display("FAIL illegal_no_side_effects: got wen=%0d ecall=%0d mstatus=%h expected %0d %0d 1800",
               n_wen, n_ecall, mem[12'h300], wen_before, ecall_before); else n_pass++;
  endtask

  task automatic test_reset_in_write();
    int wen_before;
    wen_before = n_wen;
    send(2'b00, 3'b001, 12'h300, 5'd2, 32'hDEAD_BEEF, 5'd6, 32'h0);
    tick();
    n_checks++; if (csr_wen_o !== 1'b1) $display("FAIL rstw_in_write: got %b expected 1", csr_wen_o); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({all_out, in_ready_o} !== '0) $display("FAIL rstw_outputs_zero: got %h expected 0", {all_out, in_ready_o}); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL rstw_ready_after: got %b expected 1", in_ready_o); else n_pass++;
    n_checks++; if (mem[12'h300] !== 32'h1800 || n_wen !== wen_before)
      $display("FAIL rstw_csr_unchanged: got %h wen=%0d expected 1800 %0d", mem[12'h300], n_wen, wen_before); else n_pass++;
    repeat (2) tick();
    n_checks++; if ({all_out, in_ready_o} !== {151'b0, 1'b1})
      $display("FAIL rstw_idle: got %h expected idle", {all_out, in_ready_o}); else n_pass++;
  endtask

  initial begin
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    sys_op_i = '0; funct3_i = '0; csr_index_i = '0;
    rs1_idx_i = '0; rs1_data_i = '0; rd_i = '0; pc_i = '0;
    test_reset();
    test_csrrw();
    test_set_clear();
    test_back_to_back();
    test_ecall();
    test_mret();
    test_stall();
    test_illegal();
    test_reset_in_write();
    n_checks++; if (n_overlap !== 0) $display("FAIL strobe_overlap: got %0d expected 0", n_overlap); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
